// File: rtl/seg_scan_sched_pkg.sv
// Shared constants and types for the seven-segment scan scheduler.
// Segment codes are active-high {g,f,e,d,c,b,a}.
package seg_scan_sched_pkg;

   localparam int         NUM_DIGITS = 8;
   localparam int         IDX_W      = 3;
   localparam logic [7:0] SEG_OFF    = 8'hFF;
   localparam logic [7:0] EN_OFF     = 8'hFF;

   localparam logic [6:0] SEG_HEX_0 = 7'h3F;
   localparam logic [6:0] SEG_HEX_1 = 7'h06;
   localparam logic [6:0] SEG_HEX_2 = 7'h5B;
   localparam logic [6:0] SEG_HEX_3 = 7'h4F;
   localparam logic [6:0] SEG_HEX_4 = 7'h66;
   localparam logic [6:0] SEG_HEX_5 = 7'h6D;
   localparam logic [6:0] SEG_HEX_6 = 7'h7D;
   localparam logic [6:0] SEG_HEX_7 = 7'h07;
   localparam logic [6:0] SEG_HEX_8 = 7'h7F;
   localparam logic [6:0] SEG_HEX_9 = 7'h6F;
   localparam logic [6:0] SEG_HEX_A = 7'h77;
   localparam logic [6:0] SEG_HEX_B = 7'h7C;
   localparam logic [6:0] SEG_HEX_C = 7'h39;
   localparam logic [6:0] SEG_HEX_D = 7'h5E;
   localparam logic [6:0] SEG_HEX_E = 7'h79;
   localparam logic [6:0] SEG_HEX_F = 7'h71;

   typedef enum logic {
      PH_BLANK = 1'b0,
      PH_DRIVE = 1'b1
   } phase_e;

endpackage

// File: rtl/seg_scan_sched_if.sv
// Display bus: value/mask inputs from the counter blocks and the
// active-low anode/segment drive toward the board pins.
interface seg_scan_sched_if;
   logic [31:0] data;
   logic [7:0]  dig_mask;
   logic [7:0]  dp_mask;
   logic        lz_en;
   logic [7:0]  en;
   logic [7:0]  cx;
   logic        frame_start;

   modport master (
      output data, dig_mask, dp_mask, lz_en,
      input  en, cx, frame_start
   );

   modport slave (
      input  data, dig_mask, dp_mask, lz_en,
      output en, cx, frame_start
   );
endinterface

// File: rtl/seg_scan_sched_hex_to_seg.sv
// Combinational hex nibble to active-high seven-segment decoder.
module hex_to_seg
   import seg_scan_sched_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   // nibble to segment pattern lookup
   always_comb begin
      seg = SEG_HEX_0;
      case (nib)
         4'h0:    seg = SEG_HEX_0;
         4'h1:    seg = SEG_HEX_1;
         4'h2:    seg = SEG_HEX_2;
         4'h3:    seg = SEG_HEX_3;
         4'h4:    seg = SEG_HEX_4;
         4'h5:    seg = SEG_HEX_5;
         4'h6:    seg = SEG_HEX_6;
         4'h7:    seg = SEG_HEX_7;
         4'h8:    seg = SEG_HEX_8;
         4'h9:    seg = SEG_HEX_9;
         4'hA:    seg = SEG_HEX_A;
         4'hB:    seg = SEG_HEX_B;
         4'hC:    seg = SEG_HEX_C;
         4'hD:    seg = SEG_HEX_D;
         4'hE:    seg = SEG_HEX_E;
         4'hF:    seg = SEG_HEX_F;
         default: seg = SEG_HEX_0;
      endcase
   end

endmodule

// File: rtl/seg_scan_sched.sv
// Eight-digit seven-segment scan scheduler: one digit per slot, a blanking
// interval at the start of every slot, inputs frozen once per frame.
module seg_scan_sched
   import seg_scan_sched_pkg::*;
#(
   parameter int SCAN_DIV  = 100000,
   parameter int BLANK_CYC = 2000
)(
   input  logic              clk,
   input  logic              rst,
   seg_scan_sched_if.slave   bus
);

   localparam int               CNT_W   = $clog2(SCAN_DIV);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]      cnt_r, cnt_nxt_s;
   logic [IDX_W-1:0]      idx_r, idx_nxt_s;
   logic [31:0]           data_r, data_s;
   logic [NUM_DIGITS-1:0] dig_mask_r, dig_mask_s;
   logic [NUM_DIGITS-1:0] dp_mask_r, dp_mask_s;
   logic                  lz_en_r, lz_en_s;
   logic [NUM_DIGITS-1:0] sup_s;
   logic                  snap_s, dig_on_s;
   logic [3:0]            nib_s;
   logic [6:0]            seg_s;
   phase_e                phase_s;
   logic [7:0]            en_nxt_s, cx_nxt_s, en_r, cx_r;
   logic                  fs_r;

   // On the snapshot edge the shadow is not loaded yet, so decode the incoming
   // values directly; this keeps the first cycle of a frame consistent too.
   assign snap_s     = (cnt_r == '0) && (idx_r == '0);
   assign data_s     = snap_s ? bus.data     : data_r;
   assign dig_mask_s = snap_s ? bus.dig_mask : dig_mask_r;
   assign dp_mask_s  = snap_s ? bus.dp_mask  : dp_mask_r;
   assign lz_en_s    = snap_s ? bus.lz_en    : lz_en_r;
   assign nib_s      = data_s[{idx_r, 2'b00} +: 4];

   hex_to_seg u_hex_to_seg (
      .nib (nib_s),
      .seg (seg_s)
   );

   // Slot counter, digit index and per-frame shadow registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r      <= '0;
         idx_r      <= '0;
         data_r     <= 32'h0000_0000;
         dig_mask_r <= 8'h00;
         dp_mask_r  <= 8'h00;
         lz_en_r    <= 1'b0;
      end else begin
         cnt_r <= cnt_nxt_s;
         idx_r <= idx_nxt_s;
         if (snap_s) begin
            data_r     <= bus.data;
            dig_mask_r <= bus.dig_mask;
            dp_mask_r  <= bus.dp_mask;
            lz_en_r    <= bus.lz_en;
         end
      end
   end

   // Next slot position: cnt wraps at the slot length, idx wraps 7 -> 0
   always_comb begin
      cnt_nxt_s = cnt_r;
      idx_nxt_s = idx_r;
      if (cnt_r == CNT_MAX) begin
         cnt_nxt_s = '0;
         idx_nxt_s = idx_r + 3'd1;
      end else begin
         cnt_nxt_s = cnt_r + CNT_W'(1);
         idx_nxt_s = idx_r;
      end
   end

   // Leading-zero mask: a digit is suppressed when it and all higher nibbles are 0
   always_comb begin
      logic zero_above;
      zero_above = 1'b1;
      sup_s      = '0;
      for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (data_s[i*4 +: 4] == 4'h0);
         sup_s[i]   = lz_en_s & zero_above;
      end
   end

   assign dig_on_s = dig_mask_s[idx_r] & ~sup_s[idx_r];
   assign phase_s  = (int'({1'b0, cnt_r}) < BLANK_CYC) ? PH_BLANK : PH_DRIVE;

   // Next output values for the current slot phase
   always_comb begin
      en_nxt_s = EN_OFF;
      cx_nxt_s = SEG_OFF;
      case (phase_s)
         PH_DRIVE: begin
            if (dig_on_s) begin
               en_nxt_s = ~(8'd1 << idx_r);
               cx_nxt_s = {~dp_mask_s[idx_r], ~seg_s};
            end else begin
               en_nxt_s = EN_OFF;
               cx_nxt_s = SEG_OFF;
            end
         end
         PH_BLANK: begin
            en_nxt_s = EN_OFF;
            cx_nxt_s = SEG_OFF;
         end
         default: begin
            en_nxt_s = EN_OFF;
            cx_nxt_s = SEG_OFF;
         end
      endcase
   end

   // Registered pin drive and frame marker
   always_ff @(posedge clk) begin
      if (rst) begin
         en_r <= EN_OFF;
         cx_r <= SEG_OFF;
         fs_r <= 1'b0;
      end else begin
         en_r <= en_nxt_s;
         cx_r <= cx_nxt_s;
         fs_r <= snap_s;
      end
   end

   assign bus.en          = en_r;
   assign bus.cx          = cx_r;
   assign bus.frame_start = fs_r;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Directed bench for seg_scan_sched with SCAN_DIV=4, BLANK_CYC=1: every
// slot is one blank cycle followed by three drive cycles.
module tb_seg_scan_sched;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   // slot k expectations live in byte k
   logic [63:0] exp_en_v;
   logic [63:0] exp_cx_v;

   always #5 clk = ~clk;

   seg_scan_sched_if bus ();

   seg_scan_sched #(
      .SCAN_DIV  (4),
      .BLANK_CYC (1)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_slot(input string tag, input int k, input logic fs_exp);
      step();
      chk($sformatf("%s s%0d blank en", tag, k), bus.en, 8'hFF);
      chk($sformatf("%s s%0d blank cx", tag, k), bus.cx, 8'hFF);
      chk($sformatf("%s s%0d fs", tag, k), {7'd0, bus.frame_start}, {7'd0, fs_exp});
      for (int j = 0; j < 3; j++) begin
         step();
         chk($sformatf("%s s%0d c%0d en", tag, k, j), bus.en, exp_en_v[k*8 +: 8]);
         chk($sformatf("%s s%0d c%0d cx", tag, k, j), bus.cx, exp_cx_v[k*8 +: 8]);
         chk($sformatf("%s s%0d c%0d fs", tag, k, j), {7'd0, bus.frame_start}, 8'h00);
      end
   endtask

   task automatic check_frame(input string tag, input int first, input int last);
      for (int k = first; k <= last; k++) begin
         check_slot(tag, k, (k == 0));
      end
   endtask

   task automatic set_in(input logic [31:0] d, input logic [7:0] dm,
                         input logic [7:0] dp, input logic lz);
      bus.data     = d;
      bus.dig_mask = dm;
      bus.dp_mask  = dp;
      bus.lz_en    = lz;
   endtask

   initial begin
      rst = 1'b1;
      set_in(32'h0000_0000, 8'h00, 8'h00, 1'b0);
      repeat (3) step();
      chk("reset en", bus.en, 8'hFF);
      chk("reset cx", bus.cx, 8'hFF);
      chk("reset fs", {7'd0, bus.frame_start}, 8'h00);

      // plain scan 0..7
      set_in(32'h7654_3210, 8'hFF, 8'h00, 1'b0);
      rst = 1'b0;
      exp_en_v = 64'h7FBF_DFEF_F7FB_FDFE;
      exp_cx_v = 64'hF882_9299_B0A4_F9C0;
      check_frame("scan", 0, 7);

      // mid-frame change must not tear
      check_frame("tear", 0, 2);
      bus.data = 32'hFFFF_FFFF;
      check_frame("tear", 3, 7);

      exp_cx_v = 64'h8E8E_8E8E_8E8E_8E8E;
      check_frame("allf", 0, 3);
      set_in(32'h0000_0000, 8'h05, 8'h01, 1'b0);
      check_frame("allf", 4, 7);

      // digit and decimal-point masks
      exp_en_v = 64'hFFFF_FFFF_FFFB_FFFE;
      exp_cx_v = 64'hFFFF_FFFF_FFC0_FF40;
      check_frame("mask", 0, 4);
      set_in(32'h0000_0A05, 8'hFF, 8'h00, 1'b1);
      check_frame("mask", 5, 7);

      // leading-zero suppression
      exp_en_v = 64'hFFFF_FFFF_FFFB_FDFE;
      exp_cx_v = 64'hFFFF_FFFF_FF88_C092;
      check_frame("lz", 0, 4);
      set_in(32'h0000_0000, 8'hFF, 8'hFE, 1'b1);
      check_frame("lz", 5, 7);

      // all zero with DPs requested on suppressed digits: only digit 0 lights
      exp_en_v = 64'hFFFF_FFFF_FFFF_FFFE;
      exp_cx_v = 64'hFFFF_FFFF_FFFF_FFC0;
      check_frame("lz0", 0, 4);
      set_in(32'h7654_3210, 8'hFF, 8'h00, 1'b0);
      check_frame("lz0", 5, 7);

      // reset during slot 5 drive
      exp_en_v = 64'h7FBF_DFEF_F7FB_FDFE;
      exp_cx_v = 64'hF882_9299_B0A4_F9C0;
      check_frame("rstmid", 0, 4);
      step();
      chk("rstmid s5 blank en", bus.en, 8'hFF);
      step();
      chk("rstmid s5 drive en", bus.en, 8'hDF);
      chk("rstmid s5 drive cx", bus.cx, 8'h92);
      rst = 1'b1;
      step();
      chk("rstmid hold en", bus.en, 8'hFF);
      chk("rstmid hold cx", bus.cx, 8'hFF);
      chk("rstmid hold fs", {7'd0, bus.frame_start}, 8'h00);
      step();
      rst = 1'b0;
      check_frame("restart", 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/seg_scan_sched.md
Name: seg_scan_sched

Overview:
Time-multiplexing scheduler for the 8-digit seven-segment display. It takes a 32-bit hex value plus per-digit enable and decimal-point masks, and scans one digit at a time at a programmable slot rate. Each slot starts with an anti-ghosting blanking interval. Inputs are snapshotted once per frame so a displayed frame never tears. It replaces ad-hoc digit muxing between the counter blocks and the board pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit slot; legal range >= 2.
BLANK_CYC, 2000, cycles at the start of each slot with all digits off; legal range 0..SCAN_DIV-1.

Ports:
clk  in  1  system clock, single clock domain
rst  in  1  synchronous, active-high reset
data  in  32  nibble i = hex value of digit i; digit 0 is the rightmost
dig_mask  in  8  bit i = 1 enables digit i
dp_mask  in  8  bit i = 1 lights the decimal point of digit i
lz_en  in  1  1 = suppress leading zeros
en  out  8  digit anodes, active-low
cx  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
frame_start  out  1  one-cycle pulse when slot 0 begins

Behaviour:
- Reset: cnt=0, idx=0, shadow registers=0, en=8'hFF, cx=8'hFF, frame_start=0.
- Reset mid-frame: outputs are 8'hFF on the next edge and the scan restarts at slot 0.
- Slot counter cnt runs 0..SCAN_DIV-1 and wraps. On wrap, idx increments modulo 8, so 7 goes to 0.
- Phases: BLANK while cnt < BLANK_CYC, DRIVE otherwise. BLANK_CYC=0 means no BLANK phase.
- Snapshot: on the edge where cnt=0 and idx=0, the shadow registers capture data, dig_mask, dp_mask and lz_en.
- The same edge drives frame_start=1 for exactly one cycle. The first cycle after rst deasserts is this edge.
- All decoding uses the shadow registers only. Input changes mid-frame take effect at the next frame_start.
- Leading-zero suppression (lz_en=1): digit i is blanked when its nibble and every higher nibble are 0. Digit 0 is never suppressed.
- Suppression also blanks the DP of that digit.
- BLANK phase output: en=8'hFF, cx=8'hFF.
- DRIVE phase, digit enabled and not suppressed: en=~(8'b1<<idx), cx={~dp, ~seg7(nibble idx)}.
- DRIVE phase, digit disabled or suppressed: en=8'hFF, cx=8'hFF. The slot is still consumed, which keeps duty cycle and frame period constant.
- Outputs are registered. The value present in a cycle reflects the cnt/idx state of the previous cycle, i.e. one cycle of latency.
- Frame period is exactly 8*SCAN_DIV cycles. There is no other state.
- Hex 0-F decode, active-high {g..a}: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.

Decomposition:
- seg_pkg holds NUM_DIGITS=8, SEG_OFF=8'hFF, EN_OFF=8'hFF and the 16-entry segment code constants.
- Sub-module hex_to_seg: combinational 4-bit to 7-bit decoder, instantiated once on the selected shadow nibble.
- Leading-zero mask logic stays in seg_scan_sched.

Test Plan (SCAN_DIV=4, BLANK_CYC=1):
1. Reset: hold rst high for 3 cycles → en=FF, cx=FF, frame_start=0. Release → frame_start=1 in the first cycle only, then again every 32 cycles.
2. Scan: data=32'h76543210, dig_mask=FF, dp_mask=00, lz_en=0.
   - Each slot shows 1 cycle of en=FF, cx=FF, then 3 cycles of driving.
   - Slot 0: en=FE, cx=C0. Slot 1: en=FD, cx=F9. Slot 7: en=7F, cx=F8. The scan then wraps to slot 0.
3. Tearing: change data to 32'hFFFFFFFF during slot 3 → slots 4-7 still show 4,5,6,7. After the next frame_start all slots show cx=8E.
4. Masks: dig_mask=8'h05, dp_mask=8'h01, data=0 → slot 0 gives en=FE, cx=40. Slot 1 gives en=FF throughout. Slot 2 gives en=FB, cx=C0.
5. Leading zeros: lz_en=1, data=32'h00000A05.
   - Slots 7..3 stay en=FF.
   - Slot 2 cx=88. Slot 1 cx=C0. Slot 0 cx=92.
   - With data=0 only slot 0 drives, with cx=C0.
6. Reset mid-frame: assert rst during slot 5 DRIVE → next cycle en=FF. After release the scan restarts at slot 0, with frame_start=1 in the first cycle after rst deasserts.
